// File: rtl/his_readout.sv
// his_readout: scans every histogram bin in address order, streams {bin, count} and clears each bin once it is accepted.
// Define PEAK_DETECT_EN to add the running peak tracker outputs (peak_bin, peak_count, peak_valid).
module his_readout #(
   parameter int NB = 6,
   parameter int CW = 21
) (
   input  logic          clk,
   input  logic          res,
   input  logic          start,
   output logic          mem_rd_en,
   output logic [NB-1:0] mem_rd_addr,
   input  logic [CW-1:0] mem_rd_data,
   output logic          mem_wr_en,
   output logic [NB-1:0] mem_wr_addr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [NB-1:0] out_bin,
   output logic [CW-1:0] out_count,
   output logic          out_last,
   output logic          busy,
   output logic          done
`ifdef PEAK_DETECT_EN
   ,
   output logic [NB-1:0] peak_bin,
   output logic [CW-1:0] peak_count,
   output logic          peak_valid
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_LAT  = 3'd2,
      ST_OUT  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic [NB-1:0] LAST_BIN = {NB{1'b1}};

   state_t        state_r;
   state_t        state_s;
   logic          start_acc_s;
   logic          accept_s;
   logic [NB-1:0] ptr_r;
   logic [CW-1:0] count_r;
   logic          last_r;
   logic          rd_en_r;
   logic          valid_r;
   logic          busy_r;
   logic          done_r;

   // State register
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode and handshake qualifiers
   always_comb begin
      state_s     = state_r;
      start_acc_s = 1'b0;
      accept_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s     = ST_RD;
               start_acc_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RD:   state_s = ST_LAT;
         ST_LAT:  state_s = ST_OUT;
         ST_OUT: begin
            if (out_ready) begin
               accept_s = 1'b1;
               // last bin is decided before any increment, so the pointer never wraps to 0
               if (last_r) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_RD;
               end
            end else begin
               state_s = ST_OUT;
            end
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Bin pointer, captured beat and registered strobes
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         ptr_r   <= {NB{1'b0}};
         count_r <= {CW{1'b0}};
         last_r  <= 1'b0;
         rd_en_r <= 1'b0;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         if (start_acc_s) begin
            ptr_r <= {NB{1'b0}};
         end else if (accept_s && !last_r) begin
            ptr_r <= ptr_r + NB'(1);
         end else begin
            ptr_r <= ptr_r;
         end
         if (state_r == ST_LAT) begin
            count_r <= mem_rd_data;
            last_r  <= (ptr_r == LAST_BIN);
         end else if (accept_s) begin
            count_r <= count_r;
            last_r  <= 1'b0;
         end else begin
            count_r <= count_r;
            last_r  <= last_r;
         end
         rd_en_r <= (state_s == ST_RD);
         valid_r <= (state_s == ST_OUT);
         busy_r  <= (state_s != ST_IDLE);
         done_r  <= (state_s == ST_DONE);
      end
   end

   assign mem_rd_en   = rd_en_r;
   assign mem_rd_addr = ptr_r;
   // the clear must land in the same cycle as the accepting handshake
   assign mem_wr_en   = accept_s;
   assign mem_wr_addr = ptr_r;
   assign out_valid   = valid_r;
   assign out_bin     = ptr_r;
   assign out_count   = count_r;
   assign out_last    = last_r;
   assign busy        = busy_r;
   assign done        = done_r;

`ifdef PEAK_DETECT_EN
   logic [NB-1:0] peak_bin_r;
   logic [CW-1:0] peak_count_r;
   logic          peak_valid_r;

   // Running maximum over accepted beats; strict compare keeps the lowest bin on ties
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         peak_bin_r   <= {NB{1'b0}};
         peak_count_r <= {CW{1'b0}};
         peak_valid_r <= 1'b0;
      end else begin
         if (start_acc_s) begin
            peak_bin_r   <= {NB{1'b0}};
            peak_count_r <= {CW{1'b0}};
         end else if (accept_s && (count_r > peak_count_r)) begin
            peak_bin_r   <= ptr_r;
            peak_count_r <= count_r;
         end else begin
            peak_bin_r   <= peak_bin_r;
            peak_count_r <= peak_count_r;
         end
         peak_valid_r <= (state_s == ST_DONE);
      end
   end

   assign peak_bin   = peak_bin_r;
   assign peak_count = peak_count_r;
   assign peak_valid = peak_valid_r;
`endif

endmodule

// File: tb/tb_his_readout.sv
// Directed bench for his_readout: behavioural histogram memory, per-beat checks and memory clear checks.
// Peak tracker checks are compiled in when PEAK_DETECT_EN is defined.
module tb_his_readout;

   localparam int NB    = 6;
   localparam int CW    = 21;
   localparam int NBINS = 64;

   logic          clk = 1'b0;
   logic          res = 1'b0;
   logic          start = 1'b0;
   logic          out_ready = 1'b0;
   logic          mem_rd_en;
   logic [NB-1:0] mem_rd_addr;
   logic [CW-1:0] rd_data = '0;
   logic          mem_wr_en;
   logic [NB-1:0] mem_wr_addr;
   logic          out_valid;
   logic [NB-1:0] out_bin;
   logic [CW-1:0] out_count;
   logic          out_last;
   logic          busy;
   logic          done;
`ifdef PEAK_DETECT_EN
   logic [NB-1:0] peak_bin;
   logic [CW-1:0] peak_count;
   logic          peak_valid;
`endif

   logic [CW-1:0] mem      [NBINS];
   logic [CW-1:0] init_mem [NBINS];
   logic [CW-1:0] exp_mem  [NBINS];
   int            clr_cnt  [NBINS];
   logic          ld_all = 1'b0;
   int            overlap_n = 0;
   int            n_total = 0;
   int            n_bad = 0;

   his_readout #(.NB(NB), .CW(CW)) dut (
      .clk         (clk),
      .res         (res),
      .start       (start),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_bin     (out_bin),
      .out_count   (out_count),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done)
`ifdef PEAK_DETECT_EN
      ,
      .peak_bin    (peak_bin),
      .peak_count  (peak_count),
      .peak_valid  (peak_valid)
`endif
   );

   always #5 clk = ~clk;

   // Histogram memory: one-cycle read latency, clear-on-write, bulk preload
   always @(posedge clk) begin
      if (ld_all) begin
         for (int i = 0; i < NBINS; i++) begin
            mem[6'(i)]     <= init_mem[6'(i)];
            clr_cnt[6'(i)] <= 0;
         end
      end else if (mem_wr_en) begin
         mem[mem_wr_addr]     <= '0;
         clr_cnt[mem_wr_addr] <= clr_cnt[mem_wr_addr] + 1;
      end
      if (mem_rd_en) rd_data <= mem[mem_rd_addr];
      if (mem_rd_en && mem_wr_en) overlap_n <= overlap_n + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic load_mem(input int mode);
      for (int i = 0; i < NBINS; i++) begin
         case (mode)
            0:       init_mem[6'(i)] = CW'(i + 1);
            1:       init_mem[6'(i)] = '0;
            default: init_mem[6'(i)] = (i == 12 || i == 40) ? CW'(1000) : CW'(i * 10);
         endcase
         exp_mem[6'(i)] = init_mem[6'(i)];
      end
      @(negedge clk); ld_all = 1'b1;
      @(negedge clk); ld_all = 1'b0;
   endtask

   task automatic check_mem();
      for (int i = 0; i < NBINS; i++) begin
         check_val($sformatf("mem_bin%0d", i), 32'(mem[6'(i)]), 32'(exp_mem[6'(i)]));
      end
   endtask

   // One frame: optional stall bin (10 cycles), restart pulse bin, reset-abort bin, expected start->done cycles
   task automatic run_scan(input int stall_bin, input int restart_bin, input int abort_bin, input int exp_lat);
      int nbin = 0;
      int stall_n = 0;
      int cyc = 0;
      int dones = 0;
      bit fin = 1'b0;
      bit restarted = 1'b0;
      logic [CW-1:0] exp_cnt;
      @(negedge clk); start = 1'b1; out_ready = 1'b1;
      @(negedge clk); start = 1'b0; cyc = 1;
      check_val("busy_after_start", 32'(busy), 32'd1);
      while (!fin && cyc < 3000) begin
         start = 1'b0;
         if (done) begin
            dones++;
            check_val("beats_at_done", 32'(nbin), 32'd64);
            check_val("busy_in_done", 32'(busy), 32'd1);
            if (exp_lat > 0) check_val("done_latency", 32'(cyc), 32'(exp_lat));
`ifdef PEAK_DETECT_EN
            check_val("peak_valid_with_done", 32'(peak_valid), 32'd1);
`endif
            fin = 1'b1;
         end else if (out_valid) begin
            exp_cnt = exp_mem[nbin[5:0]];
            if (nbin == restart_bin && !restarted) begin
               start = 1'b1;
               restarted = 1'b1;
            end
            if (nbin == abort_bin) begin
               out_ready = 1'b0;
               res = 1'b0;
               #1;
               check_val("rst_out_valid", 32'(out_valid), 32'd0);
               check_val("rst_busy", 32'(busy), 32'd0);
               check_val("rst_done", 32'(done), 32'd0);
               check_val("rst_rd_en", 32'(mem_rd_en), 32'd0);
               check_val("rst_wr_en", 32'(mem_wr_en), 32'd0);
               check_val("rst_out_bin", 32'(out_bin), 32'd0);
               check_val("rst_out_count", 32'(out_count), 32'd0);
               check_val("rst_out_last", 32'(out_last), 32'd0);
               repeat (2) @(negedge clk);
               res = 1'b1;
               fin = 1'b1;
            end else if (nbin == stall_bin && stall_n < 10) begin
               out_ready = 1'b0;
               stall_n++;
               #1;
               check_val("stall_bin", 32'(out_bin), 32'(nbin));
               check_val("stall_count", 32'(out_count), 32'(exp_cnt));
               check_val("stall_no_clear", 32'(mem_wr_en), 32'd0);
            end else begin
               out_ready = 1'b1;
               #1;
               check_val("beat_bin", 32'(out_bin), 32'(nbin));
               check_val("beat_count", 32'(out_count), 32'(exp_cnt));
               check_val("beat_last", 32'(out_last), 32'(nbin == 63));
               check_val("clear_strobe", 32'(mem_wr_en), 32'd1);
               check_val("clear_addr", 32'(mem_wr_addr), 32'(nbin));
               exp_mem[nbin[5:0]] = '0;
               nbin++;
            end
         end
         if (!fin) begin
            @(negedge clk);
            cyc++;
         end
      end
      check_val("scan_finished", 32'(fin), 32'd1);
      if (abort_bin < 0) begin
         repeat (4) begin
            @(negedge clk);
            if (done) dones++;
         end
         check_val("single_done", 32'(dones), 32'd1);
         check_val("idle_after_done", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_val("por_out_valid", 32'(out_valid), 32'd0);
      check_val("por_busy", 32'(busy), 32'd0);
      check_val("por_done", 32'(done), 32'd0);
      check_val("por_rd_en", 32'(mem_rd_en), 32'd0);
      check_val("por_wr_en", 32'(mem_wr_en), 32'd0);
      check_val("por_out_bin", 32'(out_bin), 32'd0);
      check_val("por_out_count", 32'(out_count), 32'd0);
      check_val("por_out_last", 32'(out_last), 32'd0);
      res = 1'b1;

      // ramp frame, always ready: bin 63 accepted at cycle 193 edge, done seen 193 cycles after start
      load_mem(0);
      run_scan(-1, -1, -1, 193);
      check_mem();

      // backpressure on bin 5
      load_mem(0);
      run_scan(5, -1, -1, 0);
      check_val("bin5_clear_once", 32'(clr_cnt[5]), 32'd1);
      check_mem();

      // start re-pulsed mid-frame
      load_mem(0);
      run_scan(-1, 20, -1, 0);
      check_mem();

      // reset while bin 30 is offered, then a fresh frame
      load_mem(0);
      run_scan(-1, -1, 30, 0);
      check_val("bin30_kept", 32'(mem[30]), 32'd31);
      check_val("bin63_kept", 32'(mem[63]), 32'd64);
      check_mem();
      run_scan(-1, -1, -1, 0);
      check_mem();

      // all-zero frame
      load_mem(1);
      run_scan(-1, -1, -1, 193);
      check_mem();

      // tied peaks at bins 12 and 40
      load_mem(2);
      run_scan(-1, -1, -1, 0);
      check_mem();
`ifdef PEAK_DETECT_EN
      check_val("peak_bin", 32'(peak_bin), 32'd12);
      check_val("peak_count", 32'(peak_count), 32'd1000);
      check_val("peak_valid_low", 32'(peak_valid), 32'd0);
`endif

      check_val("rd_wr_exclusive", 32'(overlap_n), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
